// File: rtl/sdram_burst_arbiter_pkg.sv
// Shared definitions for the SDRAM burst arbiter: FSM encoding and default geometry.
package sdram_burst_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd  = 2'd1,
        StXfer = 2'd2,
        StDone = 2'd3
    } arb_state_e;

    localparam int unsigned DefNumReq   = 3;
    localparam int unsigned DefAddrW    = 20;
    localparam int unsigned DefDataW    = 32;
    localparam int unsigned DefBurstLen = 8;

endpackage

// File: rtl/sdram_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after i_last (wrapping) wins.
module rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_winner,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    // Walk the ring starting one past the previous owner; first hit wins.
    always_comb begin
        logic [IDX_W-1:0] r_scan;
        o_winner = '0;
        o_idx    = '0;
        o_found  = 1'b0;
        r_scan   = i_last;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            r_scan = (r_scan == IDX_W'(NUM_REQ - 1)) ? '0 : r_scan + 1'b1;
            if (!o_found && i_req[r_scan]) begin
                o_found          = 1'b1;
                o_winner[r_scan] = 1'b1;
                o_idx            = r_scan;
            end
        end
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Burst-granular round-robin arbiter sharing one SDRAM command port among requesters.
module sdram_burst_arbiter
    import sdram_burst_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DefNumReq,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned BURST_LEN = DefBurstLen
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        wbeat,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [NUM_REQ-1:0]        done,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic                      mem_cmd_we,
    output logic [ADDR_W-1:0]         mem_cmd_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_wdata_ready,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_rvalid,
    output logic                      err_stray
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [IDX_W-1:0] LastRst = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(BURST_LEN);

    arb_state_e         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [IDX_W-1:0]   r_last, w_last_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_cmd_we, w_cmd_we_nxt;
    logic [ADDR_W-1:0]  r_cmd_addr, w_cmd_addr_nxt;
    logic               r_err;

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_found;
    logic               w_pick_we;
    logic [ADDR_W-1:0]  w_pick_addr;
    logic               w_wr_xfer;
    logic               w_rd_xfer;
    logic               w_beat;
    logic               w_stray;
    logic [CNT_W-1:0]   w_cnt_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_winner (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_found  (w_pick_found)
    );

    // Select the winner's command fields with constant slices.
    always_comb begin
        w_pick_we   = 1'b0;
        w_pick_addr = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
                w_pick_we   = req_we[i];
                w_pick_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_wr_xfer = (r_state == StXfer) && r_cmd_we;
    assign w_rd_xfer = (r_state == StXfer) && !r_cmd_we;
    assign w_beat    = (w_wr_xfer && mem_wdata_ready) || (w_rd_xfer && mem_rvalid);
    assign w_stray   = (mem_rvalid && !w_rd_xfer) || (mem_wdata_ready && !w_wr_xfer);
    assign w_cnt_inc = r_cnt + 1'b1;

    // Next-state logic: grant on IDLE, wait for command accept, count beats, pulse done.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_idx_nxt      = r_idx;
        w_last_nxt     = r_last;
        w_cnt_nxt      = r_cnt;
        w_cmd_we_nxt   = r_cmd_we;
        w_cmd_addr_nxt = r_cmd_addr;
        unique case (r_state)
            StIdle: begin
                if (w_pick_found) begin
                    w_grant_nxt    = w_pick_onehot;
                    w_idx_nxt      = w_pick_idx;
                    w_cmd_we_nxt   = w_pick_we;
                    w_cmd_addr_nxt = w_pick_addr;
                    w_state_nxt    = StCmd;
                end
            end
            StCmd: begin
                if (mem_cmd_ready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StXfer;
                end
            end
            StXfer: begin
                if (w_beat) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CntLast) begin
                        w_state_nxt = StDone;
                    end
                end
            end
            StDone: begin
                w_last_nxt  = r_idx;
                w_grant_nxt = '0;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_grant    <= '0;
            r_idx      <= '0;
            r_last     <= LastRst;
            r_cnt      <= '0;
            r_cmd_we   <= 1'b0;
            r_cmd_addr <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_idx      <= w_idx_nxt;
            r_last     <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cmd_we   <= w_cmd_we_nxt;
            r_cmd_addr <= w_cmd_addr_nxt;
            r_err      <= r_err | w_stray;
        end
    end

    // Owner-routed strobes and the write-data mux on the registered owner index.
    always_comb begin
        wbeat     = (w_wr_xfer && mem_wdata_ready) ? r_grant : '0;
        rvalid    = (w_rd_xfer && mem_rvalid) ? r_grant : '0;
        done      = (r_state == StDone) ? r_grant : '0;
        mem_wdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (r_idx == IDX_W'(i)) begin
                mem_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant         = r_grant;
    assign rdata         = mem_rdata;
    assign mem_cmd_valid = (r_state == StCmd);
    assign mem_cmd_we    = r_cmd_we;
    assign mem_cmd_addr  = r_cmd_addr;
    assign err_stray     = r_err;

endmodule
